gamefile_writer: RTL and testbench

- Avalon-MM slave that lets the NIOS II game loop build the 2048-bit packed gamefile word by word in a shadow buffer.
- Commits the whole buffer atomically to the live `gamefile` output at the start of vertical sync, so sprite and background renderers never see a half-updated frame.
- Sits between the Avalon bus and the gamefile unpacking logic feeding the renderers.

---
 rtl/gamefile_pkg.sv | 62 ++++++
 rtl/gamefile_vsync_edge.sv | 33 +++
 rtl/gamefile_writer.sv | 136 +++++++++++++
 tb/tb_gamefile_writer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gamefile_pkg.sv
// Shared constants for the gamefile shadow/commit block: address map, CTRL bits,
// gamefile field word indices and a byte-lane merge helper.
package gamefile_pkg;

  localparam int         GF_WORDS        = 64;
  localparam logic [5:0] GF_CTRL_ADDR    = 6'd63;
  localparam logic [5:0] GF_FCNT_ADDR    = 6'd62;
  localparam int         CTRL_COMMIT_BIT = 0;
  localparam int         CTRL_AUTO_BIT   = 1;

  // Word index of each field inside the packed gamefile
  localparam int BG              = 0;
  localparam int P1_X            = 1;
  localparam int P1_Y            = 2;
  localparam int P1_IMG          = 3;
  localparam int P1_DIR          = 4;
  localparam int SHOW            = 5;
  localparam int P2_X            = 6;
  localparam int P2_Y            = 7;
  localparam int P2_IMG          = 8;
  localparam int P2_DIR          = 9;
  localparam int P1_HP           = 10;
  localparam int P2_HP           = 11;
  localparam int P1_MP           = 12;
  localparam int P2_MP           = 13;
  localparam int P1_STATE        = 14;
  localparam int P2_STATE        = 15;
  localparam int P1_ATK_X        = 16;
  localparam int P1_ATK_Y        = 17;
  localparam int P1_ATK_IMG      = 18;
  localparam int P2_ATK_X        = 19;
  localparam int P2_ATK_Y        = 20;
  localparam int P2_ATK_IMG      = 21;
  localparam int TIMER           = 22;
  localparam int SCORE_P1        = 23;
  localparam int SCORE_P2        = 24;
  localparam int ROUND           = 25;
  localparam int BANNER_IMG      = 26;
  localparam int BANNER_X        = 27;
  localparam int BANNER_Y        = 28;
  localparam int FX0_X           = 29;
  localparam int FX0_Y           = 30;
  localparam int FX0_IMG         = 31;
  localparam int FX1_X           = 32;
  localparam int FX1_Y           = 33;
  localparam int FX1_IMG         = 34;
  localparam int HP_BAR_X        = 35;
  localparam int HP_BAR_Y        = 36;
  localparam int HP_BAR_INTERVAL = 37;

  function automatic logic [31:0] gf_byte_merge(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gamefile_vsync_edge.sv
// Synchronizes the asynchronous active-low VGA_VS into clk and flags its falling
// edge as a one-cycle frame_edge.
module gamefile_vsync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_async,
  output logic frame_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   vs_prev_q, vs_prev_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], vs_async};
    vs_prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  // Both terms are flops, so frame_edge is glitch-free and lasts one cycle
  assign frame_edge = vs_prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gamefile_writer.sv
// Avalon-MM shadow buffer for the packed gamefile, committed atomically on VS fall.
// Define GAMEFILE_FRAME_CNT_EN to turn word 62 into a read-only frame counter.
module gamefile_writer
  import gamefile_pkg::*;
#(
  parameter int NUM_WORDS   = GF_WORDS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     AVL_CS,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic [5:0]               AVL_ADDR,
  input  logic [3:0]               AVL_BYTE_EN,
  input  logic [31:0]              AVL_WRITEDATA,
  output logic [31:0]              AVL_READDATA,
  input  logic                     VGA_VS,
  output logic [32*NUM_WORDS-1:0]  gamefile,
  output logic                     commit_pulse
);

`ifdef GAMEFILE_FRAME_CNT_EN
  localparam int SHADOW_WORDS = int'(GF_FCNT_ADDR);
`else
  localparam int SHADOW_WORDS = int'(GF_CTRL_ADDR);
`endif

  logic                    frame_edge, commit, wr_en, rd_en, ctrl_wr;
  logic [31:0]             shadow_q [SHADOW_WORDS];
  logic [31:0]             shadow_d [SHADOW_WORDS];
  logic                    pending_q, pending_d, auto_q, auto_d;
  logic                    commit_pulse_q, commit_pulse_d;
  logic [31:0]             readdata_q, readdata_d;
  logic [32*NUM_WORDS-1:0] gamefile_q, gamefile_d, commit_src;

  gamefile_vsync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync_edge (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .vs_async   (VGA_VS),
    .frame_edge (frame_edge)
  );

  assign wr_en   = AVL_CS & AVL_WRITE;
  assign rd_en   = AVL_CS & AVL_READ;
  assign ctrl_wr = wr_en & (AVL_ADDR == GF_CTRL_ADDR) & AVL_BYTE_EN[0];
  assign commit  = frame_edge & (pending_q | auto_q);

`ifdef GAMEFILE_FRAME_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_edge) fcnt_d = fcnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end
`endif

  // Commit image is built from pre-write shadow state, so a same-cycle write lands only in the shadow
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_commit_src
`ifdef GAMEFILE_FRAME_CNT_EN
    if (gi == SHADOW_WORDS) begin : g_fcnt
      assign commit_src[32*gi +: 32] = fcnt_d;
    end else
`endif
    if (gi < SHADOW_WORDS) begin : g_shadow
      assign commit_src[32*gi +: 32] = shadow_q[gi];
    end else begin : g_zero
      assign commit_src[32*gi +: 32] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < SHADOW_WORDS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && AVL_ADDR == 6'(i)) begin
        shadow_d[i] = gf_byte_merge(shadow_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
      end
    end

    // A request written during the commit cycle survives the clear and targets the next frame
    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    if (ctrl_wr && AVL_WRITEDATA[CTRL_COMMIT_BIT]) pending_d = 1'b1;

    auto_d = auto_q;
    if (ctrl_wr) auto_d = AVL_WRITEDATA[CTRL_AUTO_BIT];

    gamefile_d     = commit ? commit_src : gamefile_q;
    commit_pulse_d = commit;

    readdata_d = readdata_q;
    if (rd_en) begin
      if (AVL_ADDR == GF_CTRL_ADDR) begin
        readdata_d                  = '0;
        readdata_d[CTRL_COMMIT_BIT] = pending_q;
        readdata_d[CTRL_AUTO_BIT]   = auto_q;
      end
`ifdef GAMEFILE_FRAME_CNT_EN
      else if (AVL_ADDR == GF_FCNT_ADDR) begin
        readdata_d = fcnt_q;
      end
`endif
      else begin
        readdata_d = shadow_q[AVL_ADDR];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SHADOW_WORDS; i++) shadow_q[i] <= '0;
      pending_q      <= 1'b0;
      auto_q         <= 1'b0;
      commit_pulse_q <= 1'b0;
      readdata_q     <= '0;
      gamefile_q     <= '0;
    end else begin
      for (int i = 0; i < SHADOW_WORDS; i++) shadow_q[i] <= shadow_d[i];
      pending_q      <= pending_d;
      auto_q         <= auto_d;
      commit_pulse_q <= commit_pulse_d;
      readdata_q     <= readdata_d;
      gamefile_q     <= gamefile_d;
    end
  end

  assign AVL_READDATA = readdata_q;
  assign gamefile     = gamefile_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_gamefile_writer.sv
// Randomized + directed bench for gamefile_writer: a transaction-level model feeds
// expectation queues that a negedge monitor drains against reads and commit pulses.
module tb_gamefile_writer;

  localparam int NW = 64;
  localparam int GW = 32 * NW;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          AVL_CS = 1'b0;
  logic          AVL_READ = 1'b0;
  logic          AVL_WRITE = 1'b0;
  logic [5:0]    AVL_ADDR = '0;
  logic [3:0]    AVL_BYTE_EN = '0;
  logic [31:0]   AVL_WRITEDATA = '0;
  logic [31:0]   AVL_READDATA;
  logic          VGA_VS = 1'b1;
  logic [GW-1:0] gamefile;
  logic          commit_pulse;

  gamefile_writer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .VGA_VS        (VGA_VS),
    .gamefile      (gamefile),
    .commit_pulse  (commit_pulse)
  );

  always #10 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [GW-1:0] gf;
    int            cyc;
  } commit_t;

  logic [31:0]   m_shadow [NW];
  bit            m_pending, m_auto;
  logic [31:0]   m_fcnt;
  bit            vs_d1, vs_d2, vs_d3;   // VS as sampled 1, 2 and 3 edges ago
  bit            cur_vs = 1'b1;
  commit_t       exp_commit_q[$];
  logic [31:0]   exp_rd_q[$];
  logic [GW-1:0] live_exp = '0;

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_shadow[w] = '0;
    m_pending = 0; m_auto = 0; m_fcnt = '0;
    vs_d1 = 0; vs_d2 = 0; vs_d3 = 0;
    exp_commit_q.delete();
    exp_rd_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (a == 6'd63) return {30'd0, m_auto, m_pending};
`ifdef GAMEFILE_FRAME_CNT_EN
    if (a == 6'd62) return m_fcnt;
`endif
    return m_shadow[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, predict what the coming rising edge does, wait to the next falling edge
  task automatic step(input bit cs, input bit rd, input bit wr, input logic [5:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    bit            fe;
    logic [GW-1:0] snap;
    commit_t       c;
    AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = a;
    AVL_BYTE_EN = be; AVL_WRITEDATA = d; VGA_VS = cur_vs;
    if (cs && rd) exp_rd_q.push_back(m_read(a));
    // frame edge: synchronized VS went 1->0, seen SYNC_STAGES edges after sampling
    fe = vs_d3 && !vs_d2;
    vs_d3 = vs_d2; vs_d2 = vs_d1; vs_d1 = cur_vs;
    if (fe) begin
`ifdef GAMEFILE_FRAME_CNT_EN
      m_fcnt = m_fcnt + 1;
`endif
      if (m_pending || m_auto) begin
        snap = '0;
        for (int w = 0; w < 63; w++) snap[32*w +: 32] = m_shadow[w];
`ifdef GAMEFILE_FRAME_CNT_EN
        snap[32*62 +: 32] = m_fcnt;
`endif
        c.gf = snap; c.cyc = cyc + 1;
        exp_commit_q.push_back(c);
        m_pending = 0;
      end
    end
    if (cs && wr) begin
      if (a == 6'd63) begin
        if (be[0]) begin
          m_auto = d[1];
          if (d[0]) m_pending = 1;
        end
      end
`ifdef GAMEFILE_FRAME_CNT_EN
      else if (a == 6'd62) begin
      end
`endif
      else begin
        for (int b = 0; b < 4; b++) if (be[b]) m_shadow[a][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 6'd0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1, 0, 1, a, be, d);
  endtask

  task automatic rd(input logic [5:0] a);
    step(1, 1, 0, a, 4'h0, 32'h0);
  endtask

  task automatic vs_frame(input int low_cycles, input int high_cycles);
    cur_vs = 0; idle(low_cycles);
    cur_vs = 1; idle(high_cycles);
  endtask

  task automatic reset_phase(input int n);
    RESET_N = 0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      VGA_VS = 1'(i & 1);
      @(negedge CLK);
      check("reset_readdata", AVL_READDATA, 32'h0);
      check("reset_pulse", {31'd0, commit_pulse}, 32'h0);
      check("reset_gamefile_w0", gamefile[31:0], 32'h0);
      check("reset_gamefile_w62", gamefile[32*62 +: 32], 32'h0);
    end
    cur_vs = 1; VGA_VS = 1;
    RESET_N = 1;
  endtask

  function automatic int first_diff(input logic [GW-1:0] a, input logic [GW-1:0] b);
    for (int w = 0; w < NW; w++) if (a[32*w +: 32] !== b[32*w +: 32]) return w;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  bit rd_seen = 0;
  always @(posedge CLK) rd_seen <= RESET_N && AVL_CS && AVL_READ;

  always @(negedge CLK) begin : monitor
    logic [31:0] e;
    commit_t     c;
    int          w;
    if (!RESET_N) begin
      live_exp = '0;
    end else begin
      if (rd_seen) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got %h expected no read", AVL_READDATA);
        end else begin
          e = exp_rd_q.pop_front();
          $display("cyc %0d read data=%h", cyc, AVL_READDATA);
          if (AVL_READDATA !== e) begin
            errors++;
            $display("FAIL rd_data: got %h expected %h", AVL_READDATA, e);
          end
        end
      end
      if (commit_pulse) begin
        checks++;
        if (exp_commit_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: got pulse at cyc %0d expected none", cyc);
        end else begin
          c = exp_commit_q.pop_front();
          w = first_diff(gamefile, c.gf);
          $display("cyc %0d commit w1=%h w5=%h w62=%h", cyc, gamefile[63:32], gamefile[191:160], gamefile[32*62 +: 32]);
          if (c.cyc != cyc || w >= 0) begin
            errors++;
            if (w < 0) w = 0;
            $display("FAIL commit: got cyc %0d word%0d=%h expected cyc %0d word%0d=%h",
                     cyc, w, gamefile[32*w +: 32], c.cyc, w, c.gf[32*w +: 32]);
          end
          live_exp = c.gf;
        end
      end else begin
        if (exp_commit_q.size() > 0 && exp_commit_q[0].cyc <= cyc) begin
          checks++; errors++;
          c = exp_commit_q.pop_front();
          $display("FAIL commit_missing: got no pulse expected one at cyc %0d", c.cyc);
        end
        checks++;
        w = first_diff(gamefile, live_exp);
        if (w >= 0) begin
          errors++;
          $display("FAIL gamefile_hold: got word%0d=%h expected %h", w, gamefile[32*w +: 32], live_exp[32*w +: 32]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  ra;
    logic [31:0] v;
    bit          rvs;
    reset_phase(8);
    idle(4);

    // Basic commit request
    wr(6'd1, 32'h0000_0140, 4'hF);
    wr(6'd2, 32'h0000_00F0, 4'hF);
    wr(6'd63, 32'h1, 4'hF);
    vs_frame(6, 4);
    check("p1_x_field", {22'd0, gamefile[41:32]}, 32'h140);
    check("p1_y_field", {22'd0, gamefile[73:64]}, 32'h0F0);
    rd(6'd63);
    check("ctrl_after_commit", AVL_READDATA, 32'h0);

    // Byte enables over a zero word; no commit follows
    wr(6'd0, 32'hAABB_CCDD, 4'b0101);
    rd(6'd0);
    check("byte_en_read", AVL_READDATA, 32'h00BB_00DD);
    idle(2);
    check("bg_not_committed", gamefile[31:0], 32'h0);

    // AUTO mode across three frames
    wr(6'd63, 32'h2, 4'hF);
    for (int f = 0; f < 3; f++) begin
      v = $urandom();
      wr(6'd5, v, 4'hF);
      vs_frame(5, 5);
      check("auto_show_bit0", {31'd0, gamefile[160]}, {31'd0, v[0]});
    end
    wr(6'd63, 32'h0, 4'h1);

    // Shadow write in the commit cycle
    wr(6'd3, 32'h1111_1111, 4'hF);
    wr(6'd63, 32'h1, 4'hF);
    cur_vs = 0; idle(2);
    wr(6'd3, 32'h2222_2222, 4'hF);
    idle(3);
    check("w3_old_committed", gamefile[32*3 +: 32], 32'h1111_1111);
    cur_vs = 1; idle(4);

    // COMMIT_REQ write in the commit cycle
    wr(6'd63, 32'h1, 4'hF);
    cur_vs = 0; idle(2);
    wr(6'd63, 32'h1, 4'hF);
    idle(3);
    rd(6'd63);
    check("ctrl_pending_kept", AVL_READDATA, 32'h1);
    cur_vs = 1; idle(4);
    vs_frame(5, 4);
    check("w3_new_committed", gamefile[32*3 +: 32], 32'h2222_2222);

    // Read and write together return the pre-write value
    wr(6'd10, 32'hCAFE_0001, 4'hF);
    step(1, 1, 1, 6'd10, 4'hF, 32'hBEEF_0002);
    check("rd_wr_same_cycle", AVL_READDATA, 32'hCAFE_0001);
    rd(6'd10);

    // CTRL write without BYTE_EN[0] is ignored
    wr(6'd63, 32'h3, 4'b1110);
    rd(6'd63);
    check("ctrl_be0_gate", AVL_READDATA, 32'h0);

    // Reset mid-frame with a pending request
    wr(6'd63, 32'h1, 4'hF);
    cur_vs = 0; idle(1);
    reset_phase(3);
    idle(3);
    rd(6'd63);
    check("ctrl_after_reset", AVL_READDATA, 32'h0);

    // Five frames, request on the fifth
    for (int f = 0; f < 5; f++) begin
      if (f == 4) wr(6'd63, 32'h1, 4'hF);
      vs_frame(4, 4);
    end
    rd(6'd62);
`ifdef GAMEFILE_FRAME_CNT_EN
    check("fcnt_read", AVL_READDATA, 32'd5);
    check("fcnt_committed", gamefile[2015:1984], 32'd5);
    wr(6'd62, 32'h1234, 4'hF);
    rd(6'd62);
    check("fcnt_write_ignored", AVL_READDATA, 32'd5);
`else
    check("w62_committed", gamefile[2015:1984], 32'd0);
    wr(6'd62, 32'h1234, 4'hF);
    rd(6'd62);
    check("w62_storage", AVL_READDATA, 32'h1234);
`endif

    // Randomized traffic with irregular VS
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0: ra = 6'(60 + $urandom_range(3));
        1: ra = 6'($urandom_range(5));
        default: ra = 6'($urandom_range(63));
      endcase
      rvs = ($urandom_range(5) == 0) ? !cur_vs : cur_vs;
      cur_vs = rvs;
      step($urandom_range(3) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)), ra,
           4'($urandom_range(15)), $urandom());
    end

    cur_vs = 1;
    idle(8);
    checks++;
    if (exp_commit_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got commit=%0d read=%0d left expected 0", exp_commit_q.size(), exp_rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
